// File: rtl/ks8_mp_add_seq_pkg.sv
// Shared types and constants for the byte-serial multi-precision adder.
// The sequencer state, byte width and index sizing live here so the interface and top agree.
package ks_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int BYTE_W = 8;

  function automatic int idx_width(input int nbytes);
    return $clog2(nbytes);
  endfunction

endpackage

// File: rtl/ks8_mp_add_seq_if.sv
// Operand/result handshake bundle for ks8_mp_add_seq.
// The design attaches through the slave modport; the producer/consumer side uses master.
interface ks8_mp_add_seq_if
  import ks_pkg::*;
#(
  parameter int NBYTES = 4
);

  localparam int W = BYTE_W * NBYTES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;

  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );

  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );

endinterface

// File: rtl/ks8_mp_add_seq_ks8.sv
// 8-bit Kogge-Stone adder with the legacy scrambled pin map (A on in8..in15, B on in0..in7, MSB first).
// out0 is the carry out; out1..out8 carry the sum MSB first.
module ks8 (
  input  logic in0,
  input  logic in1,
  input  logic in2,
  input  logic in3,
  input  logic in4,
  input  logic in5,
  input  logic in6,
  input  logic in7,
  input  logic in8,
  input  logic in9,
  input  logic in10,
  input  logic in11,
  input  logic in12,
  input  logic in13,
  input  logic in14,
  input  logic in15,
  output logic out0,
  output logic out1,
  output logic out2,
  output logic out3,
  output logic out4,
  output logic out5,
  output logic out6,
  output logic out7,
  output logic out8
);

  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] s;
  logic [7:0] g0, p0, g1, p1, g2, p2, g3;

  assign a = {in8, in9, in10, in11, in12, in13, in14, in15};
  assign b = {in0, in1, in2, in3, in4, in5, in6, in7};

  assign g0 = a & b;
  assign p0 = a ^ b;

  // Three prefix levels (span 1, 2, 4); g3[i] is the carry out of bits i..0 with no carry in.
  assign g1 = g0 | (p0 & {g0[6:0], 1'b0});
  assign p1 = p0 & {p0[6:0], 1'b1};
  assign g2 = g1 | (p1 & {g1[5:0], 2'b00});
  assign p2 = p1 & {p1[5:0], 2'b11};
  assign g3 = g2 | (p2 & {g2[3:0], 4'b0000});

  assign s = p0 ^ {g3[6:0], 1'b0};

  assign out0 = g3[7];
  assign {out1, out2, out3, out4, out5, out6, out7, out8} = s;

endmodule

// File: rtl/ks8_mp_add_seq.sv
// Byte-serial multi-precision add/subtract: streams one byte pair per cycle through a single ks8,
// chaining the inter-byte carry, and presents the wide result on a valid/ready output.
module ks8_mp_add_seq
  import ks_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  ks8_mp_add_seq_if.slave bus
);

  localparam int W     = BYTE_W * NBYTES;
  localparam int IDX_W = idx_width(NBYTES);

  state_t               state;
  state_t               state_next;
  logic                 in_ready;
  logic [IDX_W-1:0]     idx;
  logic                 carry;
  logic [W-1:0]         a_reg;
  logic [W-1:0]         b_reg;
  logic [W-1:0]         sum_reg;
  logic                 cout_reg;
  logic                 valid_reg;
  logic [BYTE_W-1:0]    a_byte;
  logic [BYTE_W-1:0]    b_byte;
  logic [BYTE_W-1:0]    s;
  logic [BYTE_W-1:0]    r;
  logic                 c9;
  logic                 carry_next;
  logic                 last;

  assign a_byte = a_reg[idx*BYTE_W +: BYTE_W];
  assign b_byte = b_reg[idx*BYTE_W +: BYTE_W];
  assign last   = (idx == IDX_W'(NBYTES - 1));

  ks8 u_ks8 (
    .in0 (b_byte[7]), .in1 (b_byte[6]), .in2 (b_byte[5]), .in3 (b_byte[4]),
    .in4 (b_byte[3]), .in5 (b_byte[2]), .in6 (b_byte[1]), .in7 (b_byte[0]),
    .in8 (a_byte[7]), .in9 (a_byte[6]), .in10(a_byte[5]), .in11(a_byte[4]),
    .in12(a_byte[3]), .in13(a_byte[2]), .in14(a_byte[1]), .in15(a_byte[0]),
    .out0(c9),
    .out1(s[7]), .out2(s[6]), .out3(s[5]), .out4(s[4]),
    .out5(s[3]), .out6(s[2]), .out7(s[1]), .out8(s[0])
  );

  // The incoming carry can only push the byte over when ks8 produced 0xFF, and then c9 is 0.
  assign r          = s + {{(BYTE_W-1){1'b0}}, carry};
  assign carry_next = c9 | (carry & (s == 8'hFF));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_next = RUN;
      end
      RUN: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        if (valid_reg && bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1: the inverted operand is stored and the +1 enters as the initial carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      carry     <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg <= bus.in_a;
            b_reg <= bus.in_sub ? ~bus.in_b : bus.in_b;
            carry <= bus.in_sub;
            idx   <= '0;
          end
        end
        RUN: begin
          sum_reg[idx*BYTE_W +: BYTE_W] <= r;
          carry <= carry_next;
          if (last) begin
            cout_reg  <= carry_next;
            valid_reg <= 1'b1;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) valid_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_reg;
  assign bus.out_sum   = sum_reg;
  assign bus.out_cout  = cout_reg;

endmodule

// File: tb/tb_ks8_mp_add_seq.sv
// Self-checking bench for ks8_mp_add_seq (NBYTES=4): directed, randomized, backpressure,
// back-to-back and mid-operation reset scenarios against a plain-arithmetic model.
module tb_ks8_mp_add_seq;

  localparam int NB = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  ks8_mp_add_seq_if #(.NBYTES(NB)) bus ();

  ks8_mp_add_seq #(.NBYTES(NB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: {cout, sum}. Subtract reports cout=1 when no borrow occurs.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    if (sub) return {(a >= b), a - b};
    return {1'b0, a} + {1'b0, b};
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        output logic [31:0] sum, output logic cout, output int lat,
                        output logic one_cycle);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_sub   = sub;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    sum  = bus.out_sum;
    cout = bus.out_cout;
    @(posedge clk); #1;
    one_cycle = !bus.out_valid && bus.in_ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total += 4;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    if (bus.out_sum !== 32'h0) begin bad++; $display("FAIL reset_out_sum: got %h want 0", bus.out_sum); end
    if (bus.out_cout !== 1'b0) begin bad++; $display("FAIL reset_out_cout: got %b want 0", bus.out_cout); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [31:0] va [5] = '{32'h00000001, 32'hFFFFFFFF, 32'h12345678, 32'h00000005, 32'h00000007};
    logic [31:0] vb [5] = '{32'h00000001, 32'h00000001, 32'h9ABCDEF0, 32'h00000007, 32'h00000005};
    logic        vs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] ws [5] = '{32'h00000002, 32'h00000000, 32'hACF13568, 32'hFFFFFFFE, 32'h00000002};
    logic        wc [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] sum;
    logic        cout;
    int          lat;
    logic        one;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], vs[i], sum, cout, lat, one);
      total += 4;
      if (sum !== ws[i]) begin bad++; $display("FAIL directed%0d_sum: got %h want %h", i, sum, ws[i]); end
      if (cout !== wc[i]) begin bad++; $display("FAIL directed%0d_cout: got %b want %b", i, cout, wc[i]); end
      if (lat != NB) begin bad++; $display("FAIL directed%0d_latency: got %0d want %0d", i, lat, NB); end
      if (one !== 1'b1) begin bad++; $display("FAIL directed%0d_valid_pulse: got %b want 1", i, one); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, sum;
    logic        sub, cout, one;
    logic [32:0] exp;
    int          lat;
    for (int i = 0; i < 24; i++) begin
      a   = $urandom;
      b   = (i % 4 == 0) ? ~a : $urandom;
      sub = 1'($urandom_range(0, 1));
      exp = model(a, b, sub);
      run_op(a, b, sub, sum, cout, lat, one);
      total += 3;
      if (sum !== exp[31:0]) begin bad++; $display("FAIL random%0d_sum: got %h want %h", i, sum, exp[31:0]); end
      if (cout !== exp[32]) begin bad++; $display("FAIL random%0d_cout: got %b want %b", i, cout, exp[32]); end
      if (lat != NB) begin bad++; $display("FAIL random%0d_latency: got %0d want %0d", i, lat, NB); end
    end
  endtask

  task automatic test_byte_carries();
    logic [31:0] a, b;
    int          c;
    int          guard;
    a = 32'h12345678;
    b = 32'h9ABCDEF0;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_sub = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    c = 0;
    for (int k = 0; k < NB; k++) begin
      @(posedge clk); #1;
      c = (int'(a[k*8 +: 8]) + int'(b[k*8 +: 8]) + c) >> 8;
      total++;
      if (dut.carry !== 1'(c)) begin bad++; $display("FAIL byte%0d_carry: got %b want %0d", k, dut.carry, c); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b;
    logic [32:0] exp;
    int          guard;
    a = 32'h11112222;
    b = 32'hF0F0F0F0;
    exp = model(a, b, 1'b0);
    bus.out_ready = 1'b0;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_sub = 1'b0;
    @(posedge clk); #1;
    guard = 0;
    while (!bus.out_valid && guard < 50) begin
      bus.in_a = $urandom;
      @(posedge clk); #1; guard++;
    end
    for (int k = 0; k < 5; k++) begin
      bus.in_a = $urandom;
      bus.in_b = $urandom;
      @(posedge clk); #1;
      total += 4;
      if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp%0d_valid: got %b want 1", k, bus.out_valid); end
      if (bus.out_sum !== exp[31:0]) begin bad++; $display("FAIL bp%0d_sum: got %h want %h", k, bus.out_sum, exp[31:0]); end
      if (bus.out_cout !== exp[32]) begin bad++; $display("FAIL bp%0d_cout: got %b want %b", k, bus.out_cout, exp[32]); end
      if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp%0d_in_ready: got %b want 0", k, bus.in_ready); end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    total += 2;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid: got %b want 0", bus.out_valid); end
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready: got %b want 1", bus.in_ready); end
    @(posedge clk); #1;
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_no_capture: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2;
    logic [32:0] e1, e2;
    int          n;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    e1 = model(a1, b1, 1'b0);
    e2 = model(a2, b2, 1'b1);
    n = 0;
    while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    bus.in_valid = 1'b1; bus.in_a = a1; bus.in_b = b1; bus.in_sub = 1'b0;
    @(posedge clk); #1;
    bus.in_a = a2; bus.in_b = b2; bus.in_sub = 1'b1;
    n = 0;
    while (!bus.out_valid && n < 50) begin @(posedge clk); #1; n++; end
    total += 2;
    if (n != NB) begin bad++; $display("FAIL b2b_first_latency: got %0d want %0d", n, NB); end
    if (bus.out_sum !== e1[31:0]) begin bad++; $display("FAIL b2b_first_sum: got %h want %h", bus.out_sum, e1[31:0]); end
    n = 0;
    @(posedge clk); #1; n++;
    while (!bus.out_valid && n < 50) begin @(posedge clk); #1; n++; end
    bus.in_valid = 1'b0;
    total += 3;
    if (n != NB + 2) begin bad++; $display("FAIL b2b_spacing: got %0d want %0d", n, NB + 2); end
    if (bus.out_sum !== e2[31:0]) begin bad++; $display("FAIL b2b_second_sum: got %h want %h", bus.out_sum, e2[31:0]); end
    if (bus.out_cout !== e2[32]) begin bad++; $display("FAIL b2b_second_cout: got %b want %b", bus.out_cout, e2[32]); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midrun();
    logic [31:0] sum;
    logic        cout, one;
    int          lat, guard;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    bus.in_valid = 1'b1; bus.in_a = 32'hDEADBEEF; bus.in_b = 32'h01234567; bus.in_sub = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    total += 3;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrun_out_valid: got %b want 0", bus.out_valid); end
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL midrun_in_ready: got %b want 1", bus.in_ready); end
    if (bus.out_sum !== 32'h0) begin bad++; $display("FAIL midrun_out_sum: got %h want 0", bus.out_sum); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(32'h12345678, 32'h9ABCDEF0, 1'b0, sum, cout, lat, one);
    total += 3;
    if (sum !== 32'hACF13568) begin bad++; $display("FAIL midrun_after_sum: got %h want acf13568", sum); end
    if (cout !== 1'b0) begin bad++; $display("FAIL midrun_after_cout: got %b want 0", cout); end
    if (lat != NB) begin bad++; $display("FAIL midrun_after_latency: got %0d want %0d", lat, NB); end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sub    = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_directed();
    test_byte_carries();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
